// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter slice: request/response bundles, control struct, FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package alu_arbiter_pkg;

  // Registered ALU: the result appears one cycle after its operands are presented.
  localparam int ALU_LATENCY = 1;

  // Per-operation control bits; only 'a' and 'sign' are consumed by the ALU.
  typedef struct packed {
    logic a;
    logic sign;
  } control_signals_t;

  // Everything the ALU needs for one operation.
  typedef struct packed {
    logic [2:0]       func3;
    control_signals_t cs;
    logic [31:0]      a;
    logic [31:0]      b;
  } alu_req_t;

  // Everything returned to a requester for one operation.
  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        overflow;
  } alu_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,  // nothing outstanding
    ST_INFLIGHT = 2'd1,  // op issued last cycle, ALU result live this cycle
    ST_HOLD     = 2'd2   // result parked in hold registers awaiting resp_ready
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU and response signals around the ALU arbiter.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready toward requesters, resp_valid/resp_ready back to them.
// Modports: slave = arbiter view, master = requesters plus ALU view.
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2
);

  // Requester side (one lane per requester)
  logic [NREQ-1:0]                   req_valid;
  logic [NREQ-1:0]                   req_ready;
  logic [NREQ-1:0][2:0]              req_func3;
  control_signals_t [NREQ-1:0]       req_cs;
  logic [NREQ-1:0][31:0]             req_a;
  logic [NREQ-1:0][31:0]             req_b;

  // ALU side
  logic [2:0]                        alu_func3;
  control_signals_t                  alu_cs;
  logic [31:0]                       alu_a;
  logic [31:0]                       alu_b;
  logic [31:0]                       alu_result;
  logic                              alu_zero;
  logic                              alu_overflow;

  // Response side (valid is one-hot, data is shared)
  logic [NREQ-1:0]                   resp_valid;
  logic [NREQ-1:0]                   resp_ready;
  logic [31:0]                       resp_result;
  logic                              resp_zero;
  logic                              resp_overflow;

  modport slave (
    input  req_valid, req_func3, req_cs, req_a, req_b,
    input  alu_result, alu_zero, alu_overflow,
    input  resp_ready,
    output req_ready,
    output alu_func3, alu_cs, alu_a, alu_b,
    output resp_valid, resp_result, resp_zero, resp_overflow
  );

  modport master (
    output req_valid, req_func3, req_cs, req_a, req_b,
    output alu_result, alu_zero, alu_overflow,
    output resp_ready,
    input  req_ready,
    input  alu_func3, alu_cs, alu_a, alu_b,
    input  resp_valid, resp_result, resp_zero, resp_overflow
  );

endinterface

// File: rtl/alu_arbiter_rr.sv
// Round-robin pick: first asserted req at or after ptr (wrapping mod N) gets a one-hot grant.
// Latency: purely combinational.
// Backpressure: en=0 suppresses every grant.
// Ports: req (N) in, en in, ptr ($clog2(N)) in, grant (N one-hot) out.
module alu_arbiter_rr #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic                 en,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  localparam int PW = $clog2(N);
  localparam int SW = PW + 1;

  // One spare bit so ptr+i cannot wrap before the explicit mod-N correction
  // (matters when N is not a power of two).
  logic [SW-1:0] slot;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    slot  = '0;
    for (int i = 0; i < N; i++) begin
      slot = {1'b0, ptr} + SW'(i);
      if (slot >= SW'(N)) begin
        slot = slot - SW'(N);
      end
      if (en && !found && req[slot[PW-1:0]]) begin
        grant[slot[PW-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between NREQ requesters with round-robin grant and in-order responses.
// Latency: response is presented the cycle after issue; 1 op/cycle when responses are accepted at once.
// Backpressure: an unaccepted response is parked in hold registers and blocks grants until accepted.
// Ports: clk, rst_n (async, active-low), bus (alu_arbiter_if.slave), busy (op in flight or held).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic          busy
);

  localparam int IDW = $clog2(NREQ);

  arb_state_t      state_q, state_d;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  inflight_id;
  logic            ovf_q;
  alu_resp_t       hold_resp;

  logic            can_issue;
  logic            issue;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  rr_ptr_nxt;
  alu_req_t        issue_req;
  alu_resp_t       live_resp;
  alu_resp_t       resp_mux;

  alu_arbiter_rr #(.N(NREQ)) u_rr (
    .req   (bus.req_valid),
    .en    (can_issue),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign bus.req_ready = grant;
  assign issue         = |grant;

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_id = IDW'(i);
      end
    end
  end

  assign rr_ptr_nxt = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

  // ALU inputs come from the granted lane; with no grant they are held at zero.
  always_comb begin
    issue_req = '0;
    if (issue) begin
      issue_req.func3 = bus.req_func3[grant_id];
      issue_req.cs    = bus.req_cs[grant_id];
      issue_req.a     = bus.req_a[grant_id];
      issue_req.b     = bus.req_b[grant_id];
    end
  end

  assign bus.alu_func3 = issue_req.func3;
  assign bus.alu_cs    = issue_req.cs;
  assign bus.alu_a     = issue_req.a;
  assign bus.alu_b     = issue_req.b;

  // The ALU overflow flag is combinational on the current operands, so it was
  // captured at issue; result and zero come straight from the registered ALU.
  assign live_resp = '{result: bus.alu_result, zero: bus.alu_zero, overflow: ovf_q};

  // Outputs and issue permission. In HOLD inflight_id still names the owner
  // because no grant can happen while a result is parked. can_issue is gated
  // by rst_n so no grant is shown while reset is asserted.
  always_comb begin
    can_issue      = 1'b0;
    resp_mux       = '0;
    bus.resp_valid = '0;
    unique case (state_q)
      ST_IDLE: begin
        can_issue = rst_n;
      end
      ST_INFLIGHT: begin
        bus.resp_valid[inflight_id] = 1'b1;
        resp_mux                    = live_resp;
        can_issue                   = rst_n & bus.resp_ready[inflight_id];
      end
      ST_HOLD: begin
        bus.resp_valid[inflight_id] = 1'b1;
        resp_mux                    = hold_resp;
      end
      default: begin
        can_issue = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (issue) state_d = ST_INFLIGHT;
      end
      ST_INFLIGHT: begin
        if (!bus.resp_ready[inflight_id]) state_d = ST_HOLD;
        else if (!issue)                  state_d = ST_IDLE;
      end
      ST_HOLD: begin
        if (bus.resp_ready[inflight_id]) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      inflight_id <= '0;
      ovf_q       <= 1'b0;
      hold_resp   <= '0;
    end else begin
      if (issue) begin
        inflight_id <= grant_id;
        ovf_q       <= bus.alu_overflow;
        rr_ptr      <= rr_ptr_nxt;
      end
      // The ALU result is only live for one cycle; park it if not taken.
      if (state_q == ST_INFLIGHT && !bus.resp_ready[inflight_id]) begin
        hold_resp <= live_resp;
      end
    end
  end

  assign bus.resp_result   = resp_mux.result;
  assign bus.resp_zero     = resp_mux.zero;
  assign bus.resp_overflow = resp_mux.overflow;
  assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, directed corner sequences, randomized run vs a queue model.
// Latency: a behavioural registered ALU answers one cycle after issue.
// Backpressure: resp_ready is driven directly, including long stalls and random patterns.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NREQ = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  always #5 clk = ~clk;

  alu_arbiter_if #(.NREQ(NREQ)) bus ();

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  // Behavioural ALU: returns {overflow, zero, result}. Overflow is the adder
  // carry-out for func3=0 (ADD, or SUB when sign=1), 0 otherwise.
  function automatic logic [33:0] ref_op(input logic [2:0] f3, input logic sgn,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    logic [31:0] r;
    logic        c;
    sum = {1'b0, a} + {1'b0, (sgn ? ~b : b)} + {32'd0, sgn};
    c   = 1'b0;
    case (f3)
      3'd0:    begin r = sum[31:0]; c = sum[32]; end
      3'd2:    r = {31'd0, ($signed(a) < $signed(b))};
      3'd3:    r = {31'd0, (a < b)};
      3'd4:    r = a ^ b;
      3'd6:    r = a | b;
      3'd7:    r = a & b;
      default: r = 32'd0;
    endcase
    return {c, (r == 32'd0), r};
  endfunction

  logic [33:0] alu_now;
  logic [31:0] alu_res_q;
  assign alu_now = ref_op(bus.alu_func3, bus.alu_cs.sign, bus.alu_a, bus.alu_b);
  always_ff @(posedge clk) alu_res_q <= alu_now[31:0];
  assign bus.alu_result   = alu_res_q;
  assign bus.alu_zero     = (alu_res_q == 32'd0);
  assign bus.alu_overflow = alu_now[33];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference model: queue of outstanding responses (at most one), each
  // tagged fresh (issued last cycle) or parked, plus the round-robin pointer.
  typedef struct {
    int          id;
    logic [31:0] res;
    logic        z;
    logic        o;
    bit          fresh;
  } exp_t;

  exp_t            q[$];
  int              ptr = 0;
  logic [NREQ-1:0] m_grant;
  logic [NREQ-1:0] m_acc;
  logic            m_rst;
  exp_t            m_new;
  int              m_k;

  task automatic model_check();
    logic [NREQ-1:0] eg, ev;
    logic [68:0]     e_alu;
    logic [33:0]     r;
    logic            eb;
    bit              can;
    int              k, j;
    eg = '0; ev = '0; e_alu = '0; k = -1; can = 1'b0; eb = 1'b0;
    if (rst_n) begin
      if (q.size() == 0) can = 1'b1;
      else begin
        can = q[0].fresh && bus.resp_ready[q[0].id];
        ev[q[0].id] = 1'b1;
        eb = 1'b1;
      end
      if (can) begin
        for (int i = 0; i < NREQ; i++) begin
          j = (ptr + i) % NREQ;
          if (k < 0 && bus.req_valid[j]) k = j;
        end
      end
      if (k >= 0) begin
        eg[k] = 1'b1;
        e_alu = {bus.req_func3[k], bus.req_cs[k], bus.req_a[k], bus.req_b[k]};
      end
    end
    check("req_ready", 80'(bus.req_ready), 80'(eg));
    check("resp_valid", 80'(bus.resp_valid), 80'(ev));
    check("busy", 80'(busy), 80'(eb));
    check("alu_inputs", 80'({bus.alu_func3, bus.alu_cs, bus.alu_a, bus.alu_b}), 80'(e_alu));
    if (ev != '0) begin
      check("resp_data", 80'({bus.resp_result, bus.resp_zero, bus.resp_overflow}),
            80'({q[0].res, q[0].z, q[0].o}));
    end else if (!rst_n) begin
      check("reset_resp_data", 80'({bus.resp_result, bus.resp_zero, bus.resp_overflow}), 80'(0));
    end
    m_grant = eg;
    m_acc   = ev & bus.resp_ready;
    m_rst   = rst_n;
    m_k     = k;
    if (k >= 0) begin
      r     = ref_op(bus.req_func3[k], bus.req_cs[k].sign, bus.req_a[k], bus.req_b[k]);
      m_new = '{id: k, res: r[31:0], z: r[32], o: r[33], fresh: 1'b1};
    end
  endtask

  task automatic model_update();
    if (!m_rst) begin
      q.delete();
      ptr = 0;
      return;
    end
    if (q.size() != 0) begin
      if (m_acc != '0) void'(q.pop_front());
      else q[0].fresh = 1'b0;
    end
    if (m_grant != '0) begin
      q.push_back(m_new);
      ptr = (m_k + 1) % NREQ;
    end
  endtask

  // Inputs are driven just after a negedge; step checks the model, crosses the
  // posedge, and returns at the next negedge.
  task automatic step();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive_op(input int k, input logic [2:0] f3, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b);
    bus.req_func3[k] = f3;
    bus.req_cs[k]    = '{a: 1'b0, sign: sgn};
    bus.req_a[k]     = a;
    bus.req_b[k]     = b;
  endtask

  typedef struct {
    int          k;
    logic [2:0]  f3;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
  } vec_t;

  vec_t            tv[8];
  logic [2:0]      ops[6];
  logic [NREQ-1:0] oh;
  logic [NREQ-1:0] rdy;
  logic [NREQ-1:0] exp_rv;

  initial begin
    ops   = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    tv[0] = '{0, 3'd0, 1'b0, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
    tv[1] = '{1, 3'd0, 1'b1, 32'd3,          32'd3,          32'd0,          1'b1, 1'b1};
    tv[2] = '{0, 3'd0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b1};
    tv[3] = '{1, 3'd4, 1'b0, 32'hA5A5_A5A5,  32'hFFFF_0000,  32'h5A5A_A5A5,  1'b0, 1'b0};
    tv[4] = '{0, 3'd2, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
    tv[5] = '{1, 3'd3, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
    tv[6] = '{0, 3'd0, 1'b1, 32'd1,          32'd2,          32'hFFFF_FFFF,  1'b0, 1'b0};
    tv[7] = '{1, 3'd7, 1'b0, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0,  1'b0, 1'b0};

    // Reset: requests pending, yet every output must stay at zero.
    rst_n          = 1'b0;
    bus.req_func3  = '0;
    bus.req_cs     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    drive_op(0, 3'd0, 1'b0, 32'd9, 32'd9);
    drive_op(1, 3'd0, 1'b0, 32'd8, 32'd8);
    bus.req_valid  = '1;
    bus.resp_ready = '1;
    @(negedge clk);
    #1;
    check("rst_req_ready", 80'(bus.req_ready), 80'(0));
    check("rst_resp_valid", 80'(bus.resp_valid), 80'(0));
    check("rst_busy", 80'(busy), 80'(0));
    check("rst_alu_in", 80'({bus.alu_func3, bus.alu_cs, bus.alu_a, bus.alu_b}), 80'(0));
    step();
    rst_n         = 1'b1;
    bus.req_valid = '0;
    step();

    // Single operations, each followed by its response cycle.
    for (int i = 0; i < 8; i++) begin
      drive_op(tv[i].k, tv[i].f3, tv[i].sgn, tv[i].a, tv[i].b);
      oh             = NREQ'(1) << tv[i].k;
      bus.req_valid  = oh;
      bus.resp_ready = '1;
      #1;
      check("tv_grant", 80'(bus.req_ready), 80'(oh));
      step();
      bus.req_valid = '0;
      #1;
      check("tv_resp_valid", 80'(bus.resp_valid), 80'(oh));
      check("tv_result", 80'(bus.resp_result), 80'(tv[i].res));
      check("tv_zero", 80'(bus.resp_zero), 80'(tv[i].z));
      check("tv_overflow", 80'(bus.resp_overflow), 80'(tv[i].o));
      step();
    end

    // Reset in the response cycle; pointer (now 1) must return to 0.
    drive_op(0, 3'd0, 1'b0, 32'd5, 32'd7);
    bus.req_valid = 2'b01;
    step();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    #1;
    check("midrst_resp_valid", 80'(bus.resp_valid), 80'(0));
    check("midrst_busy", 80'(busy), 80'(0));
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_busy", 80'(busy), 80'(0));
    check("post_rst_resp_valid", 80'(bus.resp_valid), 80'(0));
    step();

    // Round-robin with both requesters always valid.
    drive_op(0, 3'd0, 1'b0, 32'd10, 32'd1);
    drive_op(1, 3'd0, 1'b0, 32'd20, 32'd2);
    bus.req_valid  = 2'b11;
    bus.resp_ready = 2'b11;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("rr_grant", 80'(bus.req_ready), 80'((c % 2 == 0) ? 2'b01 : 2'b10));
      if (c > 0) begin
        exp_rv = ((c - 1) % 2 == 0) ? 2'b01 : 2'b10;
        check("rr_resp_tag", 80'(bus.resp_valid), 80'(exp_rv));
        check("rr_resp_result", 80'(bus.resp_result), 80'((exp_rv == 2'b01) ? 32'd11 : 32'd22));
      end
      step();
    end
    bus.req_valid = '0;
    step();

    // Backpressure: SUB 3-3 on requester 1 refused for three cycles.
    drive_op(1, 3'd0, 1'b1, 32'd3, 32'd3);
    drive_op(0, 3'd0, 1'b0, 32'd1, 32'd1);
    bus.req_valid  = 2'b10;
    bus.resp_ready = 2'b00;
    #1;
    check("bp_issue", 80'(bus.req_ready), 80'(2'b10));
    step();
    bus.req_valid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_no_grant", 80'(bus.req_ready), 80'(0));
      check("bp_resp_valid", 80'(bus.resp_valid), 80'(2'b10));
      check("bp_held", 80'({bus.resp_result, bus.resp_zero}), 80'({32'd0, 1'b1}));
      check("bp_busy", 80'(busy), 80'(1));
      step();
    end
    bus.resp_ready = 2'b10;
    #1;
    check("bp_accept_no_grant", 80'(bus.req_ready), 80'(0));
    check("bp_accept_valid", 80'(bus.resp_valid), 80'(2'b10));
    step();
    bus.resp_ready = 2'b11;
    #1;
    check("bp_next_grant", 80'(bus.req_ready), 80'(2'b01));
    check("bp_released", 80'(bus.resp_valid), 80'(0));
    step();
    bus.req_valid = '0;
    #1;
    check("bp_req0_resp", 80'({bus.resp_valid, bus.resp_result}), 80'({2'b01, 32'd2}));
    step();

    // Overflow capture with a new issue in the response cycle.
    drive_op(0, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    drive_op(1, 3'd0, 1'b0, 32'd1, 32'd1);
    bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b10;
    #1;
    check("ovf_b2b_grant", 80'(bus.req_ready), 80'(2'b10));
    check("ovf_resp", 80'({bus.resp_valid, bus.resp_result, bus.resp_overflow}),
          80'({2'b01, 32'd0, 1'b1}));
    step();
    bus.req_valid = '0;
    #1;
    check("ovf_next_resp", 80'({bus.resp_valid, bus.resp_result, bus.resp_overflow}),
          80'({2'b10, 32'd2, 1'b0}));
    step();

    // Idle: operands present but not valid must not reach the ALU.
    drive_op(0, 3'd0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    drive_op(1, 3'd4, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    for (int c = 0; c < 10; c++) begin
      bus.resp_ready = NREQ'($urandom_range(0, 3));
      #1;
      check("idle_alu_ab", 80'({bus.alu_a, bus.alu_b}), 80'(0));
      check("idle_resp_busy", 80'({bus.resp_valid, busy}), 80'(0));
      step();
    end

    // Randomized traffic, including occasional resets, against the model.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        drive_op(k, ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom(),
                 ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom());
        rdy[k] = ($urandom_range(0, 3) != 0);
      end
      bus.req_valid  = NREQ'($urandom_range(0, 3));
      bus.resp_ready = rdy;
      rst_n          = ($urandom_range(0, 79) != 0);
      step();
    end
    rst_n          = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = '1;
    for (int c = 0; c < 3; c++) step();
    check("drain_busy", 80'(busy), 80'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
